serial_comparator_n: RTL and testbench
======================================

SERIAL_COMPARATOR_N -- requirements
Module: serial_comparator_n

Interface
REQ-001 Parameter WIDTH, default 8: operand length in bits; legal range 2..32.
REQ-002 Parameter LSB_FIRST, default 0: 0 = bits arrive MSB-first, 1 = bits arrive LSB-first.
REQ-003 Parameter SIGNED, default 0: 0 = unsigned compare, 1 = two's-complement compare.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; reset=0 forces the reset state immediately, independent of clk.
REQ-006 start  input  1  request a new comparison; sampled only in IDLE.
REQ-007 abort  input  1  synchronous cancel of a comparison in progress.
REQ-008 bit_valid  input  1  x and y carry a valid operand bit this cycle.
REQ-009 x  input  1  serial bit of operand X.
REQ-010 y  input  1  serial bit of operand Y.
REQ-011 busy  output  1  high in RUN state.
REQ-012 done  output  1  one-cycle pulse; g_out/e_out/l_out hold a fresh result.
REQ-013 g_out  output  1  registered result: X > Y.
REQ-014 e_out  output  1  registered result: X == Y.
REQ-015 l_out  output  1  registered result: X < Y.

Function
REQ-016 FSM states IDLE, RUN, DONE; IDLE --start=1--> RUN; RUN --WIDTH-th accepted bit--> DONE; RUN --abort=1--> IDLE; DONE --> IDLE unconditionally after one cycle.
REQ-017 Entry to RUN clears the bit counter and sets the internal working flags to "equal".
REQ-018 A bit is accepted only on an edge in RUN with bit_valid=1; bit_valid=0 stalls: counter and working flags hold.
REQ-019 MSB-first: the first accepted bit position with x!=y decides the result; all later bits are ignored.
REQ-020 LSB-first: every accepted bit position with x!=y overwrites the working decision, since later bits are more significant.
REQ-021 In both orders, an unsigned differing bit gives x=1 -> greater and x=0 -> less.
REQ-022 SIGNED=1: at the sign bit, the polarity of REQ-021 is inverted (x=1,y=0 -> less); the sign bit is accepted bit 1 when MSB-first and accepted bit WIDTH when LSB-first.
REQ-023 The edge that accepts the WIDTH-th bit loads g_out/e_out/l_out from the working decision, including that final bit, and enters DONE.
REQ-024 done=1 for exactly the one cycle spent in DONE; busy=0 in IDLE and DONE.
REQ-025 g_out/e_out/l_out change only at the edge of REQ-023 or on reset, and hold their value through IDLE and the next RUN.
REQ-026 Exactly one of g_out, e_out, l_out is high at all times.
REQ-027 start is ignored in RUN and DONE; no queuing.
REQ-028 abort in RUN returns to IDLE with no done pulse, results unchanged, and the bits taken so far discarded.
REQ-029 abort in IDLE or DONE is ignored.
REQ-030 abort takes priority over a bit accepted on the same edge.
REQ-031 The bit counter width is the minimum that holds WIDTH; it never wraps past WIDTH.

Reset
REQ-032 While reset=0: state=IDLE, counter=0, working flags = equal, busy=0, done=0, g_out=0, e_out=1, l_out=0.
REQ-033 Reset asserted mid-RUN abandons the comparison immediately, and no done pulse follows deassertion.
REQ-034 After reset deassertion, the block waits in IDLE for start.

Verification
REQ-035 WIDTH=8, unsigned, MSB-first, X=0xA5, Y=0xA3, bit_valid=1 continuously -> done one cycle after the 8th bit edge; g_out=1, e_out=0, l_out=0; busy high for 8 cycles.
REQ-036 SIGNED=1, MSB-first, X=0x80, Y=0x01 -> l_out=1; the same operands with SIGNED=0 -> g_out=1.
REQ-037 LSB-first, unsigned, X=0x01, Y=0x80 -> l_out=1, because bit 7 overrides bit 0.
REQ-038 X=Y=0x5A with bit_valid low for 3 cycles after bit 4 -> done on the 11th RUN cycle, e_out=1.
REQ-039 Reset pulsed low after 4 accepted bits, where the previous result was g_out=1 -> immediately e_out=1, busy=0; no done pulse; the next start compares a fresh 8 bits.
REQ-040 abort after 5 bits, where the previous result was l_out=1 -> IDLE next cycle, no done pulse, l_out stays 1; start during DONE is ignored.

Source files
------------

// File: rtl/serial_comparator_n.sv
// Bit-serial magnitude comparator: consumes WIDTH bit pairs (MSB- or LSB-first,
// unsigned or two's complement) and registers a one-hot {greater, equal, less} result.

// One decision step: folds a single bit pair into the working one-hot flags {g,e,l}.
module serial_comparator_n_step #(
  parameter int LSB_FIRST = 0
) (
  input  logic [2:0] cur,
  input  logic       x,
  input  logic       y,
  input  logic       invert,
  output logic [2:0] nxt
);
  // MSB-first only the first difference counts; LSB-first every difference overrides.
  always_comb begin
    nxt = cur;
    if ((x != y) && ((LSB_FIRST != 0) || cur[1]))
      nxt = (x ^ invert) ? 3'b100 : 3'b001;
  end
endmodule

module serial_comparator_n #(
  parameter int WIDTH     = 8,
  parameter int LSB_FIRST = 0,
  parameter int SIGNED    = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic abort,
  input  logic bit_valid,
  input  logic x,
  input  logic y,
  output logic busy,
  output logic done,
  output logic g_out,
  output logic e_out,
  output logic l_out
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [2:0] EQUAL = 3'b010;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    flags, flags_nxt, flags_step;
  logic [2:0]    res, res_nxt;
  logic          last_bit, sign_pos;

  assign last_bit = (cnt == LAST);
  // The sign bit arrives first when MSB-first and last when LSB-first.
  assign sign_pos = (SIGNED != 0) && ((LSB_FIRST != 0) ? last_bit : (cnt == '0));

  serial_comparator_n_step #(.LSB_FIRST(LSB_FIRST)) u_step (
    .cur    (flags),
    .x      (x),
    .y      (y),
    .invert (sign_pos),
    .nxt    (flags_step)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      flags <= EQUAL;
      res   <= EQUAL;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      flags <= flags_nxt;
      res   <= res_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    flags_nxt = flags;
    res_nxt   = res;
    case (state)
      IDLE: if (start) begin
        state_nxt = RUN;
        cnt_nxt   = '0;
        flags_nxt = EQUAL;
      end
      RUN: begin
        if (abort) begin
          // Partial bits are dropped; the next start re-initialises anyway.
          state_nxt = IDLE;
          cnt_nxt   = '0;
          flags_nxt = EQUAL;
        end else if (bit_valid) begin
          flags_nxt = flags_step;
          cnt_nxt   = cnt + CW'(1);
          if (last_bit) begin
            res_nxt   = flags_step;
            state_nxt = DONE;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy  = (state == RUN);
  assign done  = (state == DONE);
  assign g_out = res[2];
  assign e_out = res[1];
  assign l_out = res[0];
endmodule

// File: tb/tb_serial_comparator_n.sv
// Runs four comparator variants (bit order x signedness) on identical operands and
// checks each against a plain integer comparison of the whole operands.
module tb_serial_comparator_n;
  localparam int W = 8;

  logic       clk, reset, start, abort, bit_valid;
  logic [3:0] x_b, y_b;
  logic [3:0] busy_o, done_o, g_o, e_o, l_o;

  int total = 0;
  int bad   = 0;
  logic [2:0] prev [4];

  // Instance k: LSB_FIRST = k[0], SIGNED = k[1].
  for (genvar k = 0; k < 4; k++) begin : g_dut
    serial_comparator_n #(.WIDTH(W), .LSB_FIRST(k % 2), .SIGNED(k / 2)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .abort     (abort),
      .bit_valid (bit_valid),
      .x         (x_b[k]),
      .y         (y_b[k]),
      .busy      (busy_o[k]),
      .done      (done_o[k]),
      .g_out     (g_o[k]),
      .e_out     (e_o[k]),
      .l_out     (l_o[k])
    );
  end

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] ref_cmp(input int k, input logic [7:0] a, input logic [7:0] b);
    int ia, ib;
    ia = (k >= 2) ? int'($signed(a)) : int'(a);
    ib = (k >= 2) ? int'($signed(b)) : int'(b);
    if (ia > ib) return 3'b100;
    if (ia == ib) return 3'b010;
    return 3'b001;
  endfunction

  function automatic logic [2:0] res_of(input int k);
    return {g_o[k], e_o[k], l_o[k]};
  endfunction

  task automatic drive_bit(input logic [7:0] a, input logic [7:0] b, input int i);
    for (int k = 0; k < 4; k++) begin
      x_b[k] = (k % 2) ? a[i] : a[W-1-i];
      y_b[k] = (k % 2) ? b[i] : b[W-1-i];
    end
  endtask

  task automatic check_results(input string tag);
    for (int k = 0; k < 4; k++) chk($sformatf("%s_res%0d", tag, k), 32'(res_of(k)), 32'(prev[k]));
  endtask

  // stall_at >= W means no stall; abort_at >= W means no abort.
  task automatic run_cmp(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input int stall_at, input int stall_len, input int abort_at,
                         input bit start_in_done);
    int busy_cnt;
    busy_cnt = 0;
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    for (int i = 0; i < W; i++) begin
      if (i == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          if (busy_o == 4'hf) busy_cnt++;
          bit_valid = 0;
          drive_bit(~a, ~b, i);
          @(negedge clk);
        end
      end
      if (busy_o == 4'hf) busy_cnt++;
      drive_bit(a, b, i);
      bit_valid = 1;
      if (i == abort_at) begin
        abort = 1;
        @(negedge clk);
        abort = 0;
        bit_valid = 0;
        chk({tag, "_abort_busy"}, 32'(busy_o), 0);
        chk({tag, "_abort_done"}, 32'(done_o), 0);
        check_results({tag, "_abort"});
        @(negedge clk);
        chk({tag, "_abort_nodone"}, 32'(done_o), 0);
        return;
      end
      @(negedge clk);
    end
    bit_valid = 0;
    chk({tag, "_busycyc"}, busy_cnt, W + ((stall_at < W) ? stall_len : 0));
    chk({tag, "_done"}, 32'(done_o), 32'hf);
    chk({tag, "_busy_in_done"}, 32'(busy_o), 0);
    for (int k = 0; k < 4; k++) prev[k] = ref_cmp(k, a, b);
    check_results(tag);
    if (start_in_done) start = 1;
    @(negedge clk);
    start = 0;
    chk({tag, "_pulse"}, 32'(done_o), 0);
    chk({tag, "_idle"}, 32'(busy_o), 0);
    @(negedge clk);
    chk({tag, "_stay_idle"}, 32'(busy_o), 0);
  endtask

  task automatic reset_mid(input string tag, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    for (int i = 0; i < 4; i++) begin
      drive_bit(a, b, i);
      bit_valid = 1;
      @(negedge clk);
    end
    #2 reset = 0;
    #1;
    for (int k = 0; k < 4; k++) prev[k] = 3'b010;
    chk({tag, "_busy"}, 32'(busy_o), 0);
    chk({tag, "_done"}, 32'(done_o), 0);
    check_results(tag);
    @(negedge clk) reset = 1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk({tag, "_nodone"}, 32'(done_o), 0);
      chk({tag, "_nobusy"}, 32'(busy_o), 0);
    end
    bit_valid = 0;
  endtask

  initial begin
    logic [7:0] a, b;
    int st, sl, ab;
    reset = 0; start = 0; abort = 0; bit_valid = 0; x_b = '0; y_b = '0;
    for (int k = 0; k < 4; k++) prev[k] = 3'b010;
    #12;
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_done", 32'(done_o), 0);
    check_results("rst");
    // start while reset is low must not be remembered
    start = 1;
    @(negedge clk) start = 0;
    reset = 1;
    repeat (2) @(negedge clk);
    chk("post_rst_idle", 32'(busy_o), 0);

    run_cmp("a5_a3", 8'hA5, 8'hA3, W, 0, W, 0);
    chk("a5_a3_g", 32'(g_o[0]), 1);
    reset_mid("rstmid", 8'h12, 8'h34);
    run_cmp("fresh", 8'h0F, 8'hF0, W, 0, W, 0);
    run_cmp("80_01", 8'h80, 8'h01, W, 0, W, 1);
    chk("80_01_signed_l", 32'(l_o[2]), 1);
    chk("80_01_unsigned_g", 32'(g_o[0]), 1);
    run_cmp("01_80", 8'h01, 8'h80, W, 0, W, 0);
    chk("01_80_lsb_l", 32'(l_o[1]), 1);
    run_cmp("5a_stall", 8'h5A, 8'h5A, 4, 3, W, 1);
    chk("5a_e", 32'(e_o), 32'hf);
    run_cmp("pre_abort", 8'h01, 8'h80, W, 0, W, 0);
    run_cmp("abort5", 8'hFF, 8'h00, W, 0, 5, 0);
    chk("abort5_l", 32'(l_o[0]), 1);
    run_cmp("abort0", 8'h00, 8'hFF, W, 0, 0, 0);
    run_cmp("7f_80", 8'h7F, 8'h80, W, 0, W, 1);
    run_cmp("ff_fe", 8'hFF, 8'hFE, 7, 2, W, 0);

    for (int n = 0; n < 60; n++) begin
      a = 8'($urandom);
      case ($urandom_range(0, 3))
        0: b = a;
        1: b = a ^ (8'h01 << $urandom_range(0, 7));
        default: b = 8'($urandom);
      endcase
      st = $urandom_range(0, 11);
      sl = $urandom_range(1, 3);
      ab = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 7) : W;
      run_cmp($sformatf("rnd%0d", n), a, b, st, sl, ab, $urandom_range(0, 1) == 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
